i2s_tx_sched: RTL and testbench
===============================

# i2s_tx_sched

Round-robin scheduler that shares the single write port of the I2S transmit FIFO between several audio sources. Each source presents samples over a valid/ready handshake. A granted source keeps the port for one complete frame of BURST_LEN words (default 2: one L+R stereo pair), so channel order in the FIFO is never interleaved between sources. It sits between the audio producers (CPU-side buffers, mixers) and the TX FIFO write side of the APB4 I2S controller.

## Interface
- NUM_REQ, 4: number of requesters, ≥2.
- DATA_WIDTH, 32: sample word width.
- BURST_LEN, 2: words per granted frame, ≥1.
- clk_i  in  1  clock.
- rst_n_i  in  1  reset. One clock; reset is synchronous and active-low.
- en_i  in  1  scheduler enable.
- req_valid_i  in  NUM_REQ  per-source word valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  per-source word; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  out  NUM_REQ  per-source word accepted when valid & ready.
- fifo_full_i  in  1  TX FIFO full; no write may be issued while high.
- fifo_wr_en_o  out  1  FIFO write strobe.
- fifo_wr_data_o  out  DATA_WIDTH  FIFO write data.
- grant_o  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy_o  out  1  high while in XFER.
- frame_done_o  out  1  one-cycle pulse after a frame completes.

## Operation
- Two states: IDLE and XFER.
- IDLE → XFER when en_i=1 and req_valid_i≠0.
  - The winner is the first valid source searching from (last_grant+1) mod NUM_REQ upward, with wrap-around.
  - Winner is registered into grant_o; beat counter is cleared.
- XFER transfer rule:
  - req_ready_o[g] = !fifo_full_i for the granted source g; all other ready bits are 0.
  - A beat occurs when req_valid_i[g] & req_ready_o[g].
  - On a beat: fifo_wr_en_o=1 and fifo_wr_data_o = data of g, both combinational in the same cycle.
  - Otherwise fifo_wr_en_o=0 and fifo_wr_data_o=0.
- Burst lock:
  - If valid drops or the FIFO fills mid-frame, the grant is held and the block waits. No timeout.
- Beat counter counts 0..BURST_LEN-1. On the beat with count=BURST_LEN-1:
  - Next state is IDLE.
  - last_grant ← g.
  - frame_done_o pulses in the following cycle.
- en_i=0 during XFER does not abort. The frame finishes, then the block stays in IDLE until en_i=1.
- en_i=0 in IDLE: no grant; all ready bits 0.
- Simultaneous requests are resolved only by the round-robin pointer. A source that just finished has lowest priority in the next arbitration.
- Reset values:
  - state=IDLE, grant_o=0, busy_o=0, frame_done_o=0, counter=0.
  - last_grant=NUM_REQ-1, so source 0 wins first after reset.
  - All ready bits 0 and fifo_wr_en_o=0.
- Reset asserted mid-frame discards the partial frame immediately at the next clock edge. No further writes occur.

## Timing
- Request in IDLE at cycle n → grant_o/busy_o high at n+1; first possible write at n+1.
- Back-to-back full-rate frame costs BURST_LEN cycles plus 1 idle arbitration cycle.
- Last beat at cycle m:
  - grant_o=0, busy_o=0 and frame_done_o=1 at m+1.
  - Next grant at m+2 at the earliest.
- fifo_full_i is sampled combinationally. Deasserting it at cycle k allows a write in cycle k.
- Write strobe, data mux and ready are combinational from grant/valid/full. All other outputs are registered.
- Beat counter width is $clog2(BURST_LEN)+1. It never exceeds BURST_LEN-1.

## Test plan
- Reset then hold only req_valid_i[2]=1, data 0xA0/0xA1, BURST_LEN=2, FIFO never full → grant_o=4'b0100 one cycle after request; writes 0xA0 then 0xA1; frame_done_o pulse; busy_o=0.
- All four sources continuously valid → frame order 0,1,2,3,0 exactly; each frame is 2 consecutive writes; 1 idle cycle between frames; no source starved.
- Source 1 granted, fifo_full_i=1 for 5 cycles after the first beat → fifo_wr_en_o=0 and req_ready_o=0 throughout; second word is written the cycle full drops; grant never changes mid-frame.
- Granted source drops valid after word 0 while source 3 is valid → grant held until the granted source supplies word 1; no write from source 3 until that frame is done.
- en_i deasserted on the cycle of the first beat → second beat still completes; then IDLE with no grant while en_i=0; re-enabling resumes round-robin from last_grant+1.
- rst_n_i=0 for one cycle after the first beat of a frame → next cycle grant_o=0, busy_o=0, no write; after release source 0 wins first.

Source files
------------

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched: round-robin, frame-locked arbiter for the I2S TX FIFO write port
module i2s_tx_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          frame_done_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN) + 1;
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_n;
  logic [IW-1:0] last_grant, g_idx, win_idx, idx;
  logic [CW-1:0] cnt;
  logic found, beat, last;
  logic [DATA_WIDTH-1:0] g_data;
  // Search starts one past the previous owner, so the last owner ranks lowest
  always_comb begin
    idx = last_grant;
    win_idx = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win_idx = idx;
      end
    end
  end
  always_comb begin
    g_data = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (grant_o[k]) g_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end
  assign beat           = (state == XFER) && |(req_valid_i & grant_o) && !fifo_full_i;
  assign last           = beat && (cnt == CW'(BURST_LEN - 1));
  assign req_ready_o    = (state == XFER && !fifo_full_i) ? grant_o : '0;
  assign fifo_wr_en_o   = beat;
  assign fifo_wr_data_o = beat ? g_data : '0;
  assign busy_o         = state == XFER;
  always_comb begin
    state_n = state;
    if (state == IDLE && en_i && found) state_n = XFER;
    if (last) state_n = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      grant_o      <= '0;
      g_idx        <= '0;
      last_grant   <= IW'(NUM_REQ - 1);
      cnt          <= '0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      frame_done_o <= last;
      if (state == IDLE && state_n == XFER) begin
        grant_o <= NUM_REQ'(1) << win_idx;
        g_idx   <= win_idx;
        cnt     <= '0;
      end else if (last) begin
        grant_o    <= '0;
        last_grant <= g_idx;
        cnt        <= '0;
      end else if (beat) begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx_sched.sv
// tb_i2s_tx_sched: cycle-table checks plus a write-data scoreboard for i2s_tx_sched
module tb_i2s_tx_sched;
  logic         clk_i = 1'b0;
  logic         rst_n_i, en_i, fifo_full_i;
  logic [3:0]   req_valid, req_ready, grant;
  logic [127:0] req_data;
  logic         wr_en, busy, done;
  logic [31:0]  wr_data;

  i2s_tx_sched dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .fifo_full_i(fifo_full_i), .fifo_wr_en_o(wr_en), .fifo_wr_data_o(wr_data),
    .grant_o(grant), .busy_o(busy), .frame_done_o(done)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic en; logic [3:0] v; logic f; logic rn;
    logic [3:0] g; logic b; logic d; logic w; logic [3:0] r;
  } vec_t;

  vec_t vq[$];
  logic [31:0] exp_q[$];
  int sc[4] = '{default: 0};
  int mdl[4] = '{default: 0};
  int n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] word(input int k, input int n);
    return {8'(k), 16'h0, 8'(8'hA0 + n)};
  endfunction

  function automatic vec_t mk(input logic en, input logic [3:0] v, input logic f, input logic rn,
                              input logic [3:0] g, input logic b, input logic d, input logic w,
                              input logic [3:0] r);
    vec_t x;
    x.en = en; x.v = v; x.f = f; x.rn = rn; x.g = g; x.b = b; x.d = d; x.w = w; x.r = r;
    return x;
  endfunction

  always_comb
    for (int k = 0; k < 4; k++) req_data[k*32 +: 32] = word(k, sc[k]);

  always @(posedge clk_i)
    for (int k = 0; k < 4; k++)
      if (req_valid[k] && req_ready[k]) sc[k] <= sc[k] + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  initial begin
    int gi;
    // single source 2 frame
    vq.push_back(mk(1, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0100, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0100, 0, 1, 4'b0100, 1, 0, 1, 4'b0100));
    vq.push_back(mk(1, 4'b0100, 0, 1, 4'b0100, 1, 0, 1, 4'b0100));
    vq.push_back(mk(1, 4'b0000, 0, 1, 4'b0000, 0, 1, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    // reset, then all four sources continuously valid: order 0,1,2,3,0
    vq.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0000));
    vq.push_back(mk(1, 4'b1111, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    for (int s = 0; s < 5; s++) begin
      vq.push_back(mk(1, 4'b1111, 0, 1, 4'(1 << (s % 4)), 1, 0, 1, 4'(1 << (s % 4))));
      vq.push_back(mk(1, 4'b1111, 0, 1, 4'(1 << (s % 4)), 1, 0, 1, 4'(1 << (s % 4))));
      vq.push_back(mk(1, s == 4 ? 4'b0000 : 4'b1111, 0, 1, 4'b0000, 0, 1, 0, 4'b0000));
    end
    // source 1, FIFO full for 5 cycles after the first beat
    vq.push_back(mk(1, 4'b0010, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0010, 0, 1, 4'b0010, 1, 0, 1, 4'b0010));
    for (int s = 0; s < 5; s++)
      vq.push_back(mk(1, 4'b0010, 1, 1, 4'b0010, 1, 0, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0010, 0, 1, 4'b0010, 1, 0, 1, 4'b0010));
    vq.push_back(mk(1, 4'b0000, 0, 1, 4'b0000, 0, 1, 0, 4'b0000));
    // source 2 stalls mid-frame while source 3 waits
    vq.push_back(mk(1, 4'b0100, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    vq.push_back(mk(1, 4'b1100, 0, 1, 4'b0100, 1, 0, 1, 4'b0100));
    vq.push_back(mk(1, 4'b1000, 0, 1, 4'b0100, 1, 0, 0, 4'b0100));
    vq.push_back(mk(1, 4'b1000, 0, 1, 4'b0100, 1, 0, 0, 4'b0100));
    vq.push_back(mk(1, 4'b1100, 0, 1, 4'b0100, 1, 0, 1, 4'b0100));
    vq.push_back(mk(1, 4'b1000, 0, 1, 4'b0000, 0, 1, 0, 4'b0000));
    vq.push_back(mk(1, 4'b1000, 0, 1, 4'b1000, 1, 0, 1, 4'b1000));
    vq.push_back(mk(1, 4'b1000, 0, 1, 4'b1000, 1, 0, 1, 4'b1000));
    vq.push_back(mk(1, 4'b0000, 0, 1, 4'b0000, 0, 1, 0, 4'b0000));
    // enable dropped on the first beat
    vq.push_back(mk(1, 4'b0011, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    vq.push_back(mk(0, 4'b0011, 0, 1, 4'b0001, 1, 0, 1, 4'b0001));
    vq.push_back(mk(0, 4'b0011, 0, 1, 4'b0001, 1, 0, 1, 4'b0001));
    vq.push_back(mk(0, 4'b0011, 0, 1, 4'b0000, 0, 1, 0, 4'b0000));
    vq.push_back(mk(0, 4'b0011, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0011, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0011, 0, 1, 4'b0010, 1, 0, 1, 4'b0010));
    vq.push_back(mk(1, 4'b0011, 0, 1, 4'b0010, 1, 0, 1, 4'b0010));
    vq.push_back(mk(1, 4'b0000, 0, 1, 4'b0000, 0, 1, 0, 4'b0000));
    // reset after the first beat of a source 2 frame
    vq.push_back(mk(1, 4'b0101, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0101, 0, 1, 4'b0100, 1, 0, 1, 4'b0100));
    vq.push_back(mk(1, 4'b0000, 0, 0, 4'b0100, 1, 0, 0, 4'b0100));
    vq.push_back(mk(1, 4'b0101, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0101, 0, 1, 4'b0001, 1, 0, 1, 4'b0001));
    vq.push_back(mk(1, 4'b0101, 0, 1, 4'b0001, 1, 0, 1, 4'b0001));
    vq.push_back(mk(1, 4'b0000, 0, 1, 4'b0000, 0, 1, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, 4'b0000));

    rst_n_i = 1'b0; en_i = 1'b0; fifo_full_i = 1'b0; req_valid = '0;
    repeat (2) @(posedge clk_i);
    foreach (vq[i]) begin
      @(posedge clk_i);
      #1;
      en_i = vq[i].en; req_valid = vq[i].v; fifo_full_i = vq[i].f; rst_n_i = vq[i].rn;
      if (vq[i].w) begin
        gi = 0;
        for (int k = 0; k < 4; k++) if (vq[i].g[k]) gi = k;
        exp_q.push_back(word(gi, mdl[gi]));
        mdl[gi]++;
      end
      @(negedge clk_i);
      chk($sformatf("grant row %0d", i), 32'(grant), 32'(vq[i].g));
      chk($sformatf("busy row %0d", i), 32'(busy), 32'(vq[i].b));
      chk($sformatf("frame_done row %0d", i), 32'(done), 32'(vq[i].d));
      chk($sformatf("wr_en row %0d", i), 32'(wr_en), 32'(vq[i].w));
      chk($sformatf("ready row %0d", i), 32'(req_ready), 32'(vq[i].r));
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected write row %0d: got data %0h want no write", i, wr_data);
        end else begin
          chk($sformatf("wr_data row %0d", i), wr_data, exp_q.pop_front());
        end
      end
    end
    chk("pending expected writes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
